// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide scheduler: FSM states,
// operation select and the LO value written on divide-by-zero.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_sched.sv
// MULT/DIV scheduler: owns HI/LO, launches the external booth multiplier or
// divider, and stalls the pipeline while a result is pending.
module muldiv_sched
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid_i,
  input  logic        issue_op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        acc_valid_i,
  input  logic        acc_sel_i,
  input  logic        acc_wr_i,
  input  logic [31:0] acc_wdata_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic        mult_start_o,
  output logic [31:0] mult_a_o,
  output logic [31:0] mult_b_o,
  input  logic        mult_done_i,
  input  logic [63:0] product_i,
  output logic        div_start_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic        div_done_i,
  input  logic [31:0] quotient_i,
  input  logic [31:0] remainder_i
);

  state_t      state_reg, state_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        mult_start_reg, mult_start_next;
  logic [31:0] mult_a_reg, mult_a_next;
  logic [31:0] mult_b_reg, mult_b_next;
  logic        div_start_reg, div_start_next;
  logic [31:0] div_a_reg, div_a_next;
  logic [31:0] div_b_reg, div_b_next;

  function automatic logic is_zero_divisor(input logic [31:0] divisor);
    return (divisor == 32'd0);
  endfunction

  always_comb begin
    state_next      = state_reg;
    hi_next         = hi_reg;
    lo_next         = lo_reg;
    mult_start_next = 1'b0;
    mult_a_next     = mult_a_reg;
    mult_b_next     = mult_b_reg;
    div_start_next  = 1'b0;
    div_a_next      = div_a_reg;
    div_b_next      = div_b_reg;

    case (state_reg)
      IDLE: begin
        if (issue_valid_i) begin
          if (issue_op_i == OP_DIV) begin
            // Divide-by-zero never reaches the divider; the result is fixed.
            if (is_zero_divisor(rt_i)) begin
              hi_next = rs_i;
              lo_next = DIV0_LO;
            end else begin
              div_start_next = 1'b1;
              div_a_next     = rs_i;
              div_b_next     = rt_i;
              state_next     = DIV_RUN;
            end
          end else begin
            mult_start_next = 1'b1;
            mult_a_next     = rs_i;
            mult_b_next     = rt_i;
            state_next      = MULT_RUN;
          end
        end else if (acc_valid_i && acc_wr_i) begin
          if (acc_sel_i) begin
            hi_next = acc_wdata_i;
          end else begin
            lo_next = acc_wdata_i;
          end
        end
      end

      MULT_RUN: begin
        if (mult_done_i) begin
          hi_next     = product_i[63:32];
          lo_next     = product_i[31:0];
          mult_a_next = 32'd0;
          mult_b_next = 32'd0;
          state_next  = IDLE;
        end
      end

      DIV_RUN: begin
        if (div_done_i) begin
          hi_next    = remainder_i;
          lo_next    = quotient_i;
          div_a_next = 32'd0;
          div_b_next = 32'd0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      hi_reg         <= 32'd0;
      lo_reg         <= 32'd0;
      mult_start_reg <= 1'b0;
      mult_a_reg     <= 32'd0;
      mult_b_reg     <= 32'd0;
      div_start_reg  <= 1'b0;
      div_a_reg      <= 32'd0;
      div_b_reg      <= 32'd0;
    end else begin
      state_reg      <= state_next;
      hi_reg         <= hi_next;
      lo_reg         <= lo_next;
      mult_start_reg <= mult_start_next;
      mult_a_reg     <= mult_a_next;
      mult_b_reg     <= mult_b_next;
      div_start_reg  <= div_start_next;
      div_a_reg      <= div_a_next;
      div_b_reg      <= div_b_next;
    end
  end

  assign busy_o  = (state_reg != IDLE);
  assign stall_o = busy_o & (issue_valid_i | acc_valid_i);
  assign rdata_o = acc_sel_i ? hi_reg : lo_reg;

  // Operand buses are forced to zero outside the owning run state.
  assign mult_start_o = mult_start_reg;
  assign mult_a_o     = (state_reg == MULT_RUN) ? mult_a_reg : 32'd0;
  assign mult_b_o     = (state_reg == MULT_RUN) ? mult_b_reg : 32'd0;
  assign div_start_o  = div_start_reg;
  assign div_a_o      = (state_reg == DIV_RUN) ? div_a_reg : 32'd0;
  assign div_b_o      = (state_reg == DIV_RUN) ? div_b_reg : 32'd0;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: behavioural booth/divider models, a read
// scoreboard checked by a monitor, and direct checks of stall/busy timing.
module tb_muldiv_sched;

  localparam int MLAT = 33;
  localparam int DLAT = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid_i, issue_op_i;
  logic [31:0] rs_i, rt_i;
  logic        acc_valid_i, acc_sel_i, acc_wr_i;
  logic [31:0] acc_wdata_i;
  logic        stall_o, busy_o;
  logic [31:0] rdata_o;
  logic        mult_start_o, div_start_o;
  logic [31:0] mult_a_o, mult_b_o, div_a_o, div_b_o;
  logic        mult_done_i, div_done_i;
  logic [63:0] product_i;
  logic [31:0] quotient_i, remainder_i;

  logic mdone_m = 1'b0, ddone_m = 1'b0, ddone_inj = 1'b0;
  int   mcnt = 0, dcnt = 0;
  int   mstarts = 0, dstarts = 0;
  int   checks = 0, errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  assign mult_done_i = mdone_m;
  assign div_done_i  = ddone_m | ddone_inj;

  muldiv_sched dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid_i), .issue_op_i(issue_op_i),
    .rs_i(rs_i), .rt_i(rt_i),
    .acc_valid_i(acc_valid_i), .acc_sel_i(acc_sel_i),
    .acc_wr_i(acc_wr_i), .acc_wdata_i(acc_wdata_i),
    .stall_o(stall_o), .busy_o(busy_o), .rdata_o(rdata_o),
    .mult_start_o(mult_start_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
    .mult_done_i(mult_done_i), .product_i(product_i),
    .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_done_i(div_done_i), .quotient_i(quotient_i), .remainder_i(remainder_i)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end else begin
      $display("ok   %s value=%0h", nm, act);
    end
  endtask

  // Booth unit model: fixed latency, done in the MLAT-th cycle after start.
  always @(negedge clk) begin
    if (mult_start_o) begin
      mcnt = 1;
      product_i = longint'($signed(mult_a_o)) * longint'($signed(mult_b_o));
    end else if (mcnt != 0 && mcnt < MLAT) begin
      mcnt++;
    end else begin
      mcnt = 0;
    end
    mdone_m = (mcnt == MLAT);
  end

  // Divider model; keeps running across a scheduler reset on purpose.
  always @(negedge clk) begin
    if (div_start_o) begin
      dcnt = 1;
      if (div_b_o != 0) begin
        quotient_i  = int'($signed(div_a_o)) / int'($signed(div_b_o));
        remainder_i = int'($signed(div_a_o)) % int'($signed(div_b_o));
      end
    end else if (dcnt != 0 && dcnt < DLAT) begin
      dcnt++;
    end else begin
      dcnt = 0;
    end
    ddone_m = (dcnt == DLAT);
  end

  always @(negedge clk) begin
    if (mult_start_o === 1'b1) mstarts++;
    if (div_start_o === 1'b1) dstarts++;
  end

  // Monitor: every completed (unstalled) read is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && acc_valid_i && !acc_wr_i && stall_o === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=none", rdata_o);
      end else begin
        check(name_q.pop_front(), {32'd0, rdata_o}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic sel, input logic [31:0] exp, input string nm, output int stalls);
    bit done = 0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    acc_valid_i = 1'b1; acc_sel_i = sel; acc_wr_i = 1'b0;
    stalls = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall_o) begin done = 1; break; end
      stalls++;
    end
    if (!done) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
      check({nm, "_timeout"}, 1, 0);
    end
    tick();
    acc_valid_i = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output logic [31:0] seen);
    bit done = 0;
    issue_valid_i = 1'b1; issue_op_i = op; rs_i = a; rt_i = b;
    stalls = 0;
    seen = 32'd0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!stall_o) begin done = 1; seen = rdata_o; break; end
      stalls++;
    end
    if (!done) check("issue_timeout", 1, 0);
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_o) begin done = 1; break; end
    end
    if (!done) check({nm, "_idle_timeout"}, 1, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, busy_cnt, stall_hi, ms0, ds0;
    logic [31:0] rv;

    rst_n = 1'b0;
    issue_valid_i = 0; issue_op_i = 0; rs_i = 0; rt_i = 0;
    acc_valid_i = 0; acc_sel_i = 0; acc_wr_i = 0; acc_wdata_i = 0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_lo", rdata_o, 0);
    check("rst_mult_start", mult_start_o, 0);
    check("rst_div_a", div_a_o, 0);
    acc_sel_i = 1'b1;
    #1 check("rst_hi", rdata_o, 0);
    acc_sel_i = 1'b0;
    tick();

    // MULT 7 * -3
    ms0 = mstarts;
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, st, rv);
    check("mult_issue_stall", st, 0);
    busy_cnt = 0; stall_hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("mult_start", mult_start_o, 1);
        check("mult_a", mult_a_o, 32'd7);
        check("mult_b", mult_b_o, 32'hFFFF_FFFD);
      end
      if (!busy_o) break;
      busy_cnt++;
      if (stall_o) stall_hi++;
    end
    check("mult_busy_cycles", busy_cnt, 33);
    check("mult_stall_cycles", stall_hi, 0);
    check("mult_a_idle_zero", mult_a_o, 0);
    check("mult_start_count", mstarts - ms0, 1);
    tick();
    rd(1'b0, 32'hFFFF_FFEB, "mult_lo", st);
    rd(1'b1, 32'hFFFF_FFFF, "mult_hi", st);

    // DIV 100 / 7 with MFLO presented while busy
    issue(1'b1, 32'd100, 32'd7, st, rv);
    tick();
    rd(1'b0, 32'd14, "div_mflo", st);
    check("div_mflo_stall_cycles", st, 19);
    check("div_busy_after", busy_o, 0);
    rd(1'b1, 32'd2, "div_mfhi", st);
    check("div_mfhi_stall_cycles", st, 0);

    // DIV by zero
    ds0 = dstarts;
    issue(1'b1, 32'd5, 32'd0, st, rv);
    check("div0_issue_stall", st, 0);
    @(negedge clk);
    check("div0_busy", busy_o, 0);
    check("div0_start", div_start_o, 0);
    tick();
    rd(1'b1, 32'd5, "div0_hi", st);
    rd(1'b0, 32'hFFFF_FFFF, "div0_lo", st);
    check("div0_start_count", dstarts - ds0, 0);

    // Back-to-back MULT: 3*5 then -2*4
    issue(1'b0, 32'd3, 32'd5, st, rv);
    acc_sel_i = 1'b0;
    issue(1'b0, 32'hFFFF_FFFE, 32'd4, st, rv);
    check("b2b_second_stall_cycles", st, 33);
    check("b2b_first_lo_between", rv, 32'd15);
    @(negedge clk);
    check("b2b_second_start", mult_start_o, 1);
    check("b2b_second_a", mult_a_o, 32'hFFFF_FFFE);
    wait_idle("b2b");
    rd(1'b0, 32'hFFFF_FFF8, "b2b_lo", st);
    rd(1'b1, 32'hFFFF_FFFF, "b2b_hi", st);

    // Reset in the middle of a DIV, then stale done pulses
    issue(1'b1, 32'd50, 32'd3, st, rv);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstdiv_busy", busy_o, 0);
    check("rstdiv_div_a", div_a_o, 0);
    check("rstdiv_lo", rdata_o, 0);
    tick();
    repeat (12) tick();
    ddone_inj = 1'b1;
    tick();
    ddone_inj = 1'b0;
    tick();
    check("rstdiv_busy_after_done", busy_o, 0);
    rd(1'b0, 32'd0, "rstdiv_lo_after_done", st);
    rd(1'b1, 32'd0, "rstdiv_hi_after_done", st);

    // MTHI then MFHI
    acc_valid_i = 1'b1; acc_sel_i = 1'b1; acc_wr_i = 1'b1; acc_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_stall", stall_o, 0);
    check("mthi_no_bypass", rdata_o, 0);
    tick();
    acc_valid_i = 1'b0; acc_wr_i = 1'b0;
    rd(1'b1, 32'hDEAD_BEEF, "mfhi_after_mthi", st);
    check("mfhi_stall_cycles", st, 0);
    rd(1'b0, 32'd0, "mflo_after_mthi", st);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
